envelope_gen: RTL and testbench

ADSR amplitude envelope stage placed directly downstream of the oscillator: it consumes the 12-bit unsigned waveform sample on each oscillator clock-enable and produces an amplitude-scaled sample for the output DAC path. A gate input drives an IDLE/ATTACK/DECAY/SUSTAIN/RELEASE state machine that ramps a 16-bit envelope level, and a two-stage pipelined signed multiply scales the sample about midscale.

---
 rtl/env_pkg.sv | 19 +
 rtl/env_scale.sv | 60 ++++++
 rtl/envelope_gen.sv | 140 ++++++++++++++
 tb/tb_envelope_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/env_pkg.sv
// Shared types and constants for the ADSR envelope stage.
package env_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

    // Offset-binary midscale code for an m-bit sample.
    function automatic logic [31:0] MID(input int m);
        return 32'd1 << (m - 1);
    endfunction

endpackage

// File: rtl/env_scale.sv
// Two-stage signed multiply that scales an offset-binary sample about midscale,
// with a valid bit riding alongside each sample.
module env_scale
    import env_pkg::*;
#(
    parameter int M = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [M-1:0] sample_in,
    input  logic [7:0]   env_level,
    output logic [M-1:0] sample_out,
    output logic         out_valid
);

    localparam logic [M-1:0] MID_CODE = M'(MID(M));

    logic signed [M-1:0] c_reg;
    logic        [7:0]   env_reg;
    logic                v1_reg;
    logic signed [M+8:0] p_reg;
    logic                v2_reg;
    logic        [M-1:0] sample_out_reg;
    logic                out_valid_reg;
    logic signed [M+8:0] p_next;

    assign p_next = c_reg * $signed({1'b0, env_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg          <= '0;
            env_reg        <= '0;
            v1_reg         <= 1'b0;
            p_reg          <= '0;
            v2_reg         <= 1'b0;
            sample_out_reg <= MID_CODE;
            out_valid_reg  <= 1'b0;
        end else begin
            // Subtracting midscale from offset binary is just an MSB flip.
            if (ce) begin
                c_reg   <= $signed(sample_in ^ MID_CODE);
                env_reg <= env_level;
            end
            v1_reg <= ce;
            if (v1_reg) begin
                p_reg <= p_next;
            end
            v2_reg <= v1_reg;
            if (v2_reg) begin
                sample_out_reg <= MID_CODE + p_reg[M+7:8];
            end
            out_valid_reg <= v2_reg;
        end
    end

    assign sample_out = sample_out_reg;
    assign out_valid  = out_valid_reg;

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator feeding a scaling pipeline for the DAC path.
// Optional ENV_RETRIG_EN: a rising gate in ATTACK/DECAY/SUSTAIN restarts ATTACK.
module envelope_gen
    import env_pkg::*;
#(
    parameter int M  = 12,
    parameter int LW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         gate,
    input  logic [7:0]   attack_rate,
    input  logic [7:0]   decay_rate,
    input  logic [7:0]   sustain_lvl,
    input  logic [7:0]   release_rate,
    input  logic [M-1:0] sample_in,
    output logic [M-1:0] sample_out,
    output logic         out_valid,
    output logic [7:0]   env_level,
    output logic         busy
);

    localparam logic [LW-1:0] LVL_MAX = LW'(LEVEL_MAX);

    env_state_t    state_reg, state_next;
    logic [LW-1:0] level_reg, level_next;
    logic          gate_q_reg;
    logic          rise, fall;
    logic [LW-1:0] target;
    logic [LW:0]   attack_sum;
    logic [LW:0]   decay_diff;

    assign rise       = ce & gate & ~gate_q_reg;
    assign fall       = ce & ~gate & gate_q_reg;
    assign target     = {sustain_lvl, {(LW-8){1'b0}}};
    assign attack_sum = {1'b0, level_reg} + {{(LW-7){1'b0}}, attack_rate};
    assign decay_diff = {1'b0, level_reg} - {{(LW-7){1'b0}}, decay_rate};

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        if (ce) begin
            unique case (state_reg)
                ENV_IDLE: begin
                    level_next = '0;
                    if (rise) state_next = ENV_ATTACK;
                end
                ENV_ATTACK: begin
                    if (fall) begin
                        state_next = ENV_RELEASE;
`ifdef ENV_RETRIG_EN
                    end else if (rise) begin
                        state_next = ENV_ATTACK;
`endif
                    end else if (attack_rate != 8'd0) begin
                        if (attack_sum >= {1'b0, LVL_MAX}) begin
                            level_next = LVL_MAX;
                            state_next = ENV_DECAY;
                        end else begin
                            level_next = attack_sum[LW-1:0];
                        end
                    end
                end
                ENV_DECAY: begin
                    if (fall) begin
                        state_next = ENV_RELEASE;
`ifdef ENV_RETRIG_EN
                    end else if (rise) begin
                        state_next = ENV_ATTACK;
`endif
                    end else if (decay_rate != 8'd0) begin
                        // A borrow out of the subtraction also lands on target.
                        if (decay_diff[LW] || (decay_diff[LW-1:0] <= target)) begin
                            level_next = target;
                            state_next = ENV_SUSTAIN;
                        end else begin
                            level_next = decay_diff[LW-1:0];
                        end
                    end
                end
                ENV_SUSTAIN: begin
                    if (fall) begin
                        state_next = ENV_RELEASE;
`ifdef ENV_RETRIG_EN
                    end else if (rise) begin
                        state_next = ENV_ATTACK;
`endif
                    end else begin
                        level_next = target;
                    end
                end
                ENV_RELEASE: begin
                    if (rise) begin
                        state_next = ENV_ATTACK;
                    end else if (release_rate != 8'd0) begin
                        if (level_reg <= {{(LW-8){1'b0}}, release_rate}) begin
                            level_next = '0;
                            state_next = ENV_IDLE;
                        end else begin
                            level_next = level_reg - {{(LW-8){1'b0}}, release_rate};
                        end
                    end
                end
                default: begin
                    state_next = ENV_IDLE;
                    level_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ENV_IDLE;
            level_reg  <= '0;
            gate_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            if (ce) gate_q_reg <= gate;
        end
    end

    assign env_level = level_reg[LW-1:LW-8];
    assign busy      = (state_reg != ENV_IDLE);

    env_scale #(
        .M(M)
    ) u_scale (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .sample_in  (sample_in),
        .env_level  (env_level),
        .sample_out (sample_out),
        .out_valid  (out_valid)
    );

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen: ADSR ramps, scaling latency, retrigger, reset.
module tb_envelope_gen;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        gate;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  sustain_lvl;
    logic [7:0]  release_rate;
    logic [11:0] sample_in;
    logic [11:0] sample_out;
    logic        out_valid;
    logic [7:0]  env_level;
    logic        busy;

    int n_cmp;
    int n_bad;

    envelope_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_lvl  (sustain_lvl),
        .release_rate (release_rate),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .env_level    (env_level),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ce(input int n);
        ce = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ce = 1'b0;
        gate = 1'b0;
        attack_rate = 8'h40;
        decay_rate = 8'hFF;
        sustain_lvl = 8'h80;
        release_rate = 8'h80;
        sample_in = 12'hFFF;

        // Reset held with ce toggling
        for (int i = 0; i < 4; i++) begin
            ce = ~ce;
            tick();
        end
        chk("rst_sample_out", 32'(sample_out), 32'h800);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_env_level", 32'(env_level), 32'h00);
        ce = 1'b0;
        rst_n = 1'b1;
        tick();

        // Attack: rise ce, then 0x40 per ce
        gate = 1'b1;
        run_ce(1);
        chk("atk_enter_busy", 32'(busy), 32'h1);
        chk("atk_enter_level", 32'(dut.level_reg), 32'h0000);
        run_ce(4);
        chk("atk_4_level", 32'(dut.level_reg), 32'h0100);
        chk("atk_4_env", 32'(env_level), 32'h01);
        run_ce(1019);
        chk("atk_1023_level", 32'(dut.level_reg), 32'hFFC0);
        run_ce(1);
        chk("atk_1024_level", 32'(dut.level_reg), 32'hFFFF);

        // Decay at 0xFF per ce to sustain 0x8000
        run_ce(1);
        chk("dec_1_level", 32'(dut.level_reg), 32'hFF00);
        run_ce(127);
        chk("dec_128_level", 32'(dut.level_reg), 32'h807F);
        chk("dec_128_env", 32'(env_level), 32'h80);
        run_ce(1);
        chk("dec_129_level", 32'(dut.level_reg), 32'h8000);

        // Sustain tracks sustain_lvl
        sustain_lvl = 8'h90;
        run_ce(1);
        chk("sus_track_env", 32'(env_level), 32'h90);
        sustain_lvl = 8'h80;
        run_ce(1);
        chk("sus_back_level", 32'(dut.level_reg), 32'h8000);

        // Scaling with env_level 0x80, single ce
        ce = 1'b0;
        repeat (4) tick();
        sample_in = 12'hFFF;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        chk("scl_n0_valid", 32'(out_valid), 32'h0);
        tick();
        chk("scl_n1_valid", 32'(out_valid), 32'h0);
        tick();
        chk("scl_n2_valid", 32'(out_valid), 32'h1);
        chk("scl_fff", 32'(sample_out), 32'hBFF);
        tick();
        chk("scl_n3_valid", 32'(out_valid), 32'h0);
        chk("scl_hold", 32'(sample_out), 32'hBFF);

        // Back-to-back ce
        sample_in = 12'h000;
        ce = 1'b1;
        tick();
        sample_in = 12'hFFF;
        tick();
        ce = 1'b0;
        tick();
        chk("b2b_0_valid", 32'(out_valid), 32'h1);
        chk("b2b_000", 32'(sample_out), 32'h400);
        tick();
        chk("b2b_1_valid", 32'(out_valid), 32'h1);
        chk("b2b_fff", 32'(sample_out), 32'hBFF);
        tick();
        chk("b2b_2_valid", 32'(out_valid), 32'h0);
        chk("b2b_level_kept", 32'(dut.level_reg), 32'h8000);

        // Release at 0x80 per ce
        gate = 1'b0;
        run_ce(1);
        chk("rel_enter_level", 32'(dut.level_reg), 32'h8000);
        chk("rel_enter_busy", 32'(busy), 32'h1);
        run_ce(255);
        chk("rel_255_level", 32'(dut.level_reg), 32'h0080);
        chk("rel_255_busy", 32'(busy), 32'h1);
        run_ce(1);
        chk("rel_256_level", 32'(dut.level_reg), 32'h0000);
        chk("rel_256_busy", 32'(busy), 32'h0);
        chk("rel_256_env", 32'(env_level), 32'h00);

        // Retrigger: 1->0->1 mid-decay
        attack_rate = 8'hFF;
        decay_rate = 8'h10;
        release_rate = 8'h10;
        gate = 1'b1;
        run_ce(1);
        run_ce(257);
        chk("rt_atk_top", 32'(dut.level_reg), 32'hFFFF);
        run_ce(2);
        chk("rt_dec_level", 32'(dut.level_reg), 32'hFFDF);
        gate = 1'b0;
        run_ce(1);
        chk("rt_fall_level", 32'(dut.level_reg), 32'hFFDF);
        run_ce(1);
        chk("rt_rel_level", 32'(dut.level_reg), 32'hFFCF);
        gate = 1'b1;
        run_ce(1);
        chk("rt_rise_level", 32'(dut.level_reg), 32'hFFCF);
        attack_rate = 8'h01;
        run_ce(1);
        chk("rt_atk_step", 32'(dut.level_reg), 32'hFFD0);

        // Zero rate stalls attack
        attack_rate = 8'h00;
        run_ce(5);
        chk("stall_level", 32'(dut.level_reg), 32'hFFD0);
        chk("stall_busy", 32'(busy), 32'h1);

        // Asynchronous reset with a sample in flight
        sample_in = 12'hFFF;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_sample_out", 32'(sample_out), 32'h800);
        chk("arst_env", 32'(env_level), 32'h00);
        tick();
        chk("arst_valid_a", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("arst_valid_b", 32'(out_valid), 32'h0);
        tick();
        chk("arst_valid_c", 32'(out_valid), 32'h0);
        chk("arst_sample_hold", 32'(sample_out), 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
